// File: rtl/plic_pkg.sv
// plic_pkg: shared gateway state type, register offsets and build-time defaults.
`ifndef PLIC_NUM_SOURCES
`define PLIC_NUM_SOURCES 32
`endif
`ifndef PLIC_AXI_ADDR_WIDTH
`define PLIC_AXI_ADDR_WIDTH 32
`endif
`ifndef PLIC_GW_BASE_ADDR
`define PLIC_GW_BASE_ADDR 32'h0000_1000
`endif
package plic_pkg;
  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_SERV} gw_state_e;
  localparam logic [7:0] GW_TRIG_OFS     = 8'h00;
  localparam logic [7:0] GW_POL_OFS      = 8'h04;
  localparam logic [7:0] GW_PEND_OFS     = 8'h08;
  localparam logic [7:0] GW_SERV_OFS     = 8'h0C;
  localparam logic [7:0] GW_CLAIM_OFS    = 8'h10;
  localparam logic [7:0] GW_COMPLETE_OFS = 8'h14;
endpackage

// File: rtl/plic_gw_src.sv
// plic_gw_src: one interrupt source - synchroniser, polarity, edge detect,
// pending/in-service FSM and saturating edge counter.
module plic_gw_src
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_trig,
  input  logic i_pol,
  input  logic i_pol_nxt,
  input  logic i_cfg_chg,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_serv
);
  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);
  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_req, r_req_d;
  logic [EDGE_CNT_W-1:0] r_cnt;
  gw_state_e r_state;
  logic w_edge, w_inc, w_requeue;
  assign w_edge    = r_req & ~r_req_d;
  assign w_inc     = i_trig && w_edge && r_cnt != CNT_MAX;
  assign w_requeue = i_trig && (r_cnt != '0 || w_edge);
  assign o_serv    = r_state == GW_SERV;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_req     <= 1'b0;
      r_req_d   <= 1'b0;
      r_cnt     <= '0;
      r_state   <= GW_IDLE;
      o_pending <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (i_cfg_chg) begin
        // reload both req stages with the new polarity so no false edge appears
        r_req     <= r_sync[SYNC_STAGES-1] ^ i_pol_nxt;
        r_req_d   <= r_sync[SYNC_STAGES-1] ^ i_pol_nxt;
        r_cnt     <= '0;
        r_state   <= GW_IDLE;
        o_pending <= 1'b0;
      end else begin
        r_req   <= r_sync[SYNC_STAGES-1] ^ i_pol;
        r_req_d <= r_req;
        case (r_state)
          GW_IDLE: if (i_trig ? w_edge : r_req) begin
            r_state   <= GW_PEND;
            o_pending <= 1'b1;
          end
          GW_PEND: begin
            if (w_inc) r_cnt <= r_cnt + CNT_ONE;
            if (!i_trig && !r_req) begin
              r_state   <= GW_IDLE;
              o_pending <= 1'b0;
            end else if (i_claim) begin
              r_state   <= GW_SERV;
              o_pending <= 1'b0;
            end
          end
          GW_SERV: if (i_complete) begin
            r_state   <= w_requeue ? GW_PEND : GW_IDLE;
            o_pending <= w_requeue;
            if (i_trig && r_cnt != '0) r_cnt <= r_cnt - {{(EDGE_CNT_W-1){1'b0}}, ~w_edge};
          end else if (w_inc) r_cnt <= r_cnt + CNT_ONE;
          default: begin
            r_state   <= GW_IDLE;
            o_pending <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/plic_gateway.sv
// plic_gateway: interrupt gateway in front of plic - config registers, claim/complete
// decode and read mux around NUM_SOURCES per-source gateways.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES = `PLIC_NUM_SOURCES,
  parameter int ADDR_WIDTH  = `PLIC_AXI_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4,
  parameter logic [ADDR_WIDTH-1:0] GW_BASE_ADDR = ADDR_WIDTH'(`PLIC_GW_BASE_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  i_waddr,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_wstrb,
  input  logic                   i_wen,
  input  logic [ADDR_WIDTH-1:0]  i_raddr,
  output logic [31:0]            o_rdata,
  input  logic [NUM_SOURCES-1:0] i_irq_raw,
  output logic [NUM_SOURCES-1:0] o_irq_pending
);
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [7:0] ofs);
    return GW_BASE_ADDR + ADDR_WIDTH'(ofs);
  endfunction
  logic [31:0] w_mask, w_trig_full, w_pol_full;
  logic [NUM_SOURCES-1:0] r_trig, r_pol, w_trig_nxt, w_pol_nxt, w_chg, w_claim, w_complete, w_serv;
  logic w_trig_wr, w_pol_wr, w_claim_wr, w_complete_wr;
  assign w_mask        = {{8{i_wstrb[3]}}, {8{i_wstrb[2]}}, {8{i_wstrb[1]}}, {8{i_wstrb[0]}}};
  assign w_trig_wr     = i_wen && i_waddr == addr_of(GW_TRIG_OFS);
  assign w_pol_wr      = i_wen && i_waddr == addr_of(GW_POL_OFS);
  assign w_claim_wr    = i_wen && i_wstrb[0] && i_waddr == addr_of(GW_CLAIM_OFS);
  assign w_complete_wr = i_wen && i_wstrb[0] && i_waddr == addr_of(GW_COMPLETE_OFS);
  assign w_trig_full   = (32'(r_trig) & ~w_mask) | (i_wdata & w_mask);
  assign w_pol_full    = (32'(r_pol) & ~w_mask) | (i_wdata & w_mask);
  assign w_trig_nxt    = w_trig_wr ? w_trig_full[NUM_SOURCES-1:0] : r_trig;
  assign w_pol_nxt     = w_pol_wr ? w_pol_full[NUM_SOURCES-1:0] : r_pol;
  assign w_chg         = (w_trig_nxt ^ r_trig) | (w_pol_nxt ^ r_pol);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig <= '0;
      r_pol  <= '0;
    end else begin
      r_trig <= w_trig_nxt;
      r_pol  <= w_pol_nxt;
    end
  end
  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    assign w_claim[g]    = w_claim_wr && i_wdata[7:0] == 8'(g);
    assign w_complete[g] = w_complete_wr && i_wdata[7:0] == 8'(g);
    plic_gw_src #(.SYNC_STAGES(SYNC_STAGES), .EDGE_CNT_W(EDGE_CNT_W)) u_src (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_raw      (i_irq_raw[g]),
      .i_trig     (r_trig[g]),
      .i_pol      (r_pol[g]),
      .i_pol_nxt  (w_pol_nxt[g]),
      .i_cfg_chg  (w_chg[g]),
      .i_claim    (w_claim[g]),
      .i_complete (w_complete[g]),
      .o_pending  (o_irq_pending[g]),
      .o_serv     (w_serv[g])
    );
  end
  assign o_rdata = i_raddr == addr_of(GW_TRIG_OFS) ? 32'(r_trig) :
                   i_raddr == addr_of(GW_POL_OFS)  ? 32'(r_pol) :
                   i_raddr == addr_of(GW_PEND_OFS) ? 32'(o_irq_pending) :
                   i_raddr == addr_of(GW_SERV_OFS) ? 32'(w_serv) : 32'h0;
endmodule
